mac_seq: RTL

Sequencer for a single `mac` lane, or for a row of lanes sharing control, in the systolic array. It accepts a tile length `cfg_k` and streams exactly `cfg_k` operand beats into the MAC. It drives the MAC's `en`, `m_valid` and `m_first` controls with the multiplier latency compensated. It flags the accumulator output with `y_valid` after the accumulator latency, and stalls the whole lane on output backpressure.

---
 rtl/mac_seq_pkg.sv | 18 +
 rtl/mac_seq_if.sv | 31 +++
 rtl/mac_seq_tag_pipe.sv | 51 +++++
 rtl/mac_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types for the MAC lane sequencer: FSM state encoding and the
// per-beat tag that travels alongside the MAC datapath.
package mac_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mac_seq_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } mac_tag_t;

  localparam mac_tag_t TAG_NONE = '{valid: 1'b0, first: 1'b0, last: 1'b0};

endpackage

// File: rtl/mac_seq_if.sv
// Control bundle between a MAC lane sequencer and the logic around it.
// The master side feeds tile lengths, operand beats and output acceptance;
// the slave side (the sequencer) drives the MAC controls and status.
interface mac_seq_if #(
  parameter int WC = 16
) ();

  logic          cfg_valid;
  logic          cfg_ready;
  logic [WC-1:0] cfg_k;
  logic          cfg_err;
  logic          s_valid;
  logic          s_ready;
  logic          en;
  logic          m_valid;
  logic          m_first;
  logic          y_valid;
  logic          y_ready;
  logic          busy;

  modport master (
    output cfg_valid, cfg_k, s_valid, y_ready,
    input  cfg_ready, cfg_err, s_ready, en, m_valid, m_first, y_valid, busy
  );

  modport slave (
    input  cfg_valid, cfg_k, s_valid, y_ready,
    output cfg_ready, cfg_err, s_ready, en, m_valid, m_first, y_valid, busy
  );

endinterface

// File: rtl/mac_seq_tag_pipe.sv
// Enable-gated shift register of beat tags. Each stage advances only when
// the lane enable is high, so the tags stay aligned with a stalled MAC.
module mac_tag_pipe
  import mac_seq_pkg::*;
#(
  parameter int N = 1
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     en,
  input  mac_tag_t tag_i,
  output mac_tag_t tag_o,
  output logic     any_valid
);

  mac_tag_t stage_q [N];
  mac_tag_t stage_d [N];

  // Shift one stage toward the output whenever the lane is enabled
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = tag_i;
      for (int i = 1; i < N; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers, cleared on reset so in-flight beats are dropped
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // Any live beat anywhere in the pipe keeps the lane reported as busy
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_o = stage_q[N-1];

endmodule

// File: rtl/mac_seq.sv
// Sequencer for one MAC lane (or a row of lanes sharing control). Takes a
// tile length, admits exactly that many operand beats, and delays the
// first/last qualifiers to line up with the MAC's multiplier and
// accumulator latencies. Output backpressure stalls the whole lane.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int LM = 1,
  parameter int LA = 1,
  parameter int WC = 16
) (
  input  logic      clk,
  input  logic      rstn,
  mac_seq_if.slave  bus
);

  mac_seq_state_t state_q, state_d;
  logic [WC-1:0]  cnt_q, cnt_d;
  logic           first_q, first_d;

  logic [WC-1:0]  cfg_k_w;
  logic           en;
  logic           s_ready;
  logic           beat;
  logic           last_beat;
  logic           cfg_ready;
  logic           cfg_fire;
  logic           cfg_err;
  mac_tag_t       m_tag_in, m_tag;
  mac_tag_t       y_tag_in, y_tag;
  logic           m_any, y_any;
  logic           y_valid;
  logic           unused_y_bits;

  assign cfg_k_w = bus.cfg_k;

  // Lane-wide enable: freeze everything while a finished result waits
  always_comb begin
    en = !(y_valid && !bus.y_ready);
  end

  // Handshakes, counter/FSM next state and the tag injected this cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    s_ready   = rstn && en && (state_q == RUN);
    beat      = bus.s_valid && s_ready;
    last_beat = beat && (cnt_q == '0);
    cfg_ready = rstn && en && ((state_q == IDLE) || last_beat);
    cfg_fire  = bus.cfg_valid && cfg_ready;
    cfg_err   = cfg_fire && (cfg_k_w == '0);

    if (beat) begin
      first_d = 1'b0;
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - WC'(1);
      end
    end

    if (cfg_fire && (cfg_k_w != '0)) begin
      cnt_d   = cfg_k_w - WC'(1);
      first_d = 1'b1;
      state_d = RUN;
    end

    m_tag_in = '{valid: beat, first: beat && first_q, last: last_beat};
  end

  // FSM, beat counter and first-beat marker
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  mac_tag_pipe #(.N(LM)) u_m_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .tag_i     (m_tag_in),
    .tag_o     (m_tag),
    .any_valid (m_any)
  );

  // Only the end-of-tile marker needs to ride through the accumulator delay
  always_comb begin
    y_tag_in = '{valid: m_tag.valid & m_tag.last,
                 first: 1'b0,
                 last:  m_tag.valid & m_tag.last};
  end

  mac_tag_pipe #(.N(LA)) u_y_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .tag_i     (y_tag_in),
    .tag_o     (y_tag),
    .any_valid (y_any)
  );

  assign y_valid       = y_tag.valid;
  assign unused_y_bits = y_tag.first ^ y_tag.last;

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_err   = cfg_err;
  assign bus.s_ready   = s_ready;
  assign bus.en        = en;
  assign bus.m_valid   = m_tag.valid;
  assign bus.m_first   = m_tag.valid & m_tag.first;
  assign bus.y_valid   = y_valid;
  assign bus.busy      = (state_q == RUN) | m_any | y_any;

endmodule
